// File: rtl/bike_pkg.sv
// Shared constants and FSM state type for the bicycle speed meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bike_pkg;

    localparam int KMH_W = 7;
    localparam int CLK_HZ = 2048;
    localparam logic [KMH_W-1:0] KMH_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'd0,
        ST_MEASURE    = 2'd1,
        ST_DIVIDE     = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle: quotient = dividend / divisor.
// Latency: start sampled on edge 0, 16 iterations on edges 1..16, done high in the following cycle.
// Backpressure: start is ignored while busy; done is a single-cycle pulse with quotient stable.
module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    logic [15:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] den_q, den_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [16:0] rem_shift;
    logic [16:0] rem_diff;

    // Load operands on start, otherwise shift in one quotient bit per busy cycle.
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        den_d     = den_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, quo_q[15]};
        rem_diff  = rem_shift - {1'b0, den_q};
        if (start && !busy_q) begin
            quo_d  = dividend;
            rem_d  = '0;
            den_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_shift >= {1'b0, den_q}) begin
                rem_d = rem_diff[15:0];
                quo_d = {quo_q[14:0], 1'b1};
            end else begin
                rem_d = rem_shift[15:0];
                quo_d = {quo_q[14:0], 1'b0};
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/speed_meter.sv
// Wheel speed meter: measures reed-sensor edge spacing and outputs km/h = CIRC_K / period (max 99).
// Latency: kmh/kmh_valid update 18 cycles after an accepted edge pulse; optional SPEED_AVG_EN averages q with q_prev.
// Backpressure: none; kmh_valid is a one-cycle strobe, edges arriving during a division are dropped.
module speed_meter
    import bike_pkg::*;
#(
    parameter int CIRC_K     = 15748,
    parameter int MIN_PERIOD = 100,
    parameter int TIMEOUT    = 8192
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wheel,
    output logic [KMH_W-1:0] kmh,
    output logic             kmh_valid
);

    logic             sync1_q, sync2_q, sync3_q;
    logic             edge_pulse;
    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [16:0]      cnt_plus1;
    logic [KMH_W-1:0] kmh_q, kmh_d;
    logic             kmh_vld_q, kmh_vld_d;
    logic             div_start, div_busy, div_done;
    logic [15:0]      div_quo;
    logic [KMH_W-1:0] q_sat;
    logic [KMH_W-1:0] kmh_new;
`ifdef SPEED_AVG_EN
    logic [KMH_W-1:0] q_prev_q, q_prev_d;
    logic [KMH_W:0]   avg_sum;
`endif

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= wheel;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_pulse = sync2_q & ~sync3_q;
    assign cnt_plus1  = {1'b0, cnt_q} + 17'd1;

    // The divider captures cnt+1 as its divisor, so it holds the latched period.
    seq_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (16'(CIRC_K)),
        .divisor  (cnt_plus1[15:0]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Floor is inherent in the divider; clamp to the display range here.
    always_comb begin
        q_sat = (div_quo > 16'(KMH_MAX)) ? KMH_MAX : div_quo[KMH_W-1:0];
`ifdef SPEED_AVG_EN
        avg_sum = {1'b0, q_sat} + {1'b0, q_prev_q} + 8'd1;
        kmh_new = avg_sum[KMH_W:1];
`else
        kmh_new = q_sat;
`endif
    end

    // Measurement FSM, saturating period counter and output update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q >= 16'(TIMEOUT)) ? 16'(TIMEOUT) : cnt_q + 16'd1;
        kmh_d     = kmh_q;
        kmh_vld_d = 1'b0;
        div_start = 1'b0;
`ifdef SPEED_AVG_EN
        q_prev_d  = q_prev_q;
`endif
        case (state_q)
            ST_WAIT_FIRST: begin
                if (edge_pulse) begin
                    cnt_d   = '0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // Timeout wins over a coincident edge: a period that long reads as stopped.
                if (cnt_q == 16'(TIMEOUT)) begin
                    kmh_d     = '0;
                    kmh_vld_d = 1'b1;
                    state_d   = ST_WAIT_FIRST;
`ifdef SPEED_AVG_EN
                    q_prev_d  = '0;
`endif
                end else if (edge_pulse && (cnt_plus1 >= 17'(MIN_PERIOD)) && !div_busy) begin
                    cnt_d     = '0;
                    div_start = 1'b1;
                    state_d   = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    kmh_d     = kmh_new;
                    kmh_vld_d = 1'b1;
                    state_d   = ST_MEASURE;
`ifdef SPEED_AVG_EN
                    q_prev_d  = q_sat;
`endif
                end
            end
            default: state_d = ST_WAIT_FIRST;
        endcase
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_WAIT_FIRST;
            cnt_q     <= '0;
            kmh_q     <= '0;
            kmh_vld_q <= 1'b0;
`ifdef SPEED_AVG_EN
            q_prev_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kmh_q     <= kmh_d;
            kmh_vld_q <= kmh_vld_d;
`ifdef SPEED_AVG_EN
            q_prev_q  <= q_prev_d;
`endif
        end
    end

    assign kmh       = kmh_q;
    assign kmh_valid = kmh_vld_q;

endmodule

// File: tb/tb_speed_meter.sv
// Directed testbench for speed_meter: edge spacing scenarios, timeout, reset during division.
// Latency: strobe expected 20 cycles after wheel rises (2 sync cycles + 18).
// Backpressure: n/a.
module tb_speed_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       wheel;
    logic [6:0] kmh;
    logic       kmh_valid;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int c;
        int k;
    } ev_t;
    ev_t  evq[$];
    logic prev_vld = 1'b0;

`ifdef SPEED_AVG_EN
    localparam int EXP_B = 8;
    localparam int EXP_C = 47;
    localparam int EXP_D = 89;
    localparam int EXP_F = 57;
    localparam int EXP_H = 15;
    localparam int EXP_M = 8;
`else
    localparam int EXP_B = 15;
    localparam int EXP_C = 78;
    localparam int EXP_D = 99;
    localparam int EXP_F = 15;
    localparam int EXP_H = 15;
    localparam int EXP_M = 15;
`endif

    int t_h;
    int t_m;

    speed_meter dut (
        .clk       (clk),
        .reset     (reset),
        .wheel     (wheel),
        .kmh       (kmh),
        .kmh_valid (kmh_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe with its cycle stamp; strobes must never be back to back.
    always @(negedge clk) begin
        if (kmh_valid) begin
            checks++;
            if (prev_vld) begin
                failures++;
                $display("FAIL back_to_back_strobe at cyc=%0d: kmh_valid high two cycles in a row", cyc);
            end
            evq.push_back('{cyc, int'(kmh)});
        end
        prev_vld = kmh_valid;
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic edge_at(input int t);
        wait_to(t);
        wheel = 1'b1;
        repeat (5) @(negedge clk);
        wheel = 1'b0;
    endtask

    task automatic check_strobe(input string nm, input int exp_c, input int exp_k);
        ev_t ev;
        checks++;
        if (evq.size() == 0) begin
            failures++;
            $display("FAIL %s: no strobe, required kmh=%0d at cyc=%0d", nm, exp_k, exp_c);
        end else begin
            ev = evq.pop_front();
            if (ev.c !== exp_c || ev.k !== exp_k) begin
                failures++;
                $display("FAIL %s: got kmh=%0d at cyc=%0d, required kmh=%0d at cyc=%0d",
                         nm, ev.k, ev.c, exp_k, exp_c);
            end
        end
    endtask

    task automatic check_none(input string nm);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL %s: got %0d strobe(s), first kmh=%0d at cyc=%0d, required none",
                     nm, evq.size(), evq[0].k, evq[0].c);
            evq.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wheel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (kmh !== 7'd0) begin
            failures++;
            $display("FAIL reset_kmh: got %0d required 0", kmh);
        end
        checks++;
        if (kmh_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_kmh_valid: got %b required 0", kmh_valid);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // First edge only arms the meter; second edge 1000 cycles later gives 15 km/h.
    task automatic test_basic(output int t_b);
        int a;
        a = cyc + 10;
        edge_at(a);
        wait_to(a + 40);
        check_none("first_edge_no_strobe");
        t_b = a + 1000;
        edge_at(t_b);
        wait_to(t_b + 30);
        check_strobe("period_1000", t_b + 20, EXP_B);
        checks++;
        if (kmh !== 7'(EXP_B)) begin
            failures++;
            $display("FAIL kmh_hold: got %0d required %0d", kmh, EXP_B);
        end
    endtask

    task automatic test_speeds(input int t_b, output int t_d);
        int c;
        c = t_b + 200;
        edge_at(c);
        wait_to(c + 30);
        check_strobe("period_200", c + 20, EXP_C);
        t_d = c + 100;
        edge_at(t_d);
        wait_to(t_d + 30);
        check_strobe("period_100_saturate", t_d + 20, EXP_D);
    endtask

    // Too-short edges must not clear the counter, so the next period spans from the accepted edge.
    task automatic test_short_edges(input int t_d, output int t_hh);
        int f;
        edge_at(t_d + 99);
        wait_to(t_d + 130);
        check_none("period_99_ignored");
        f = t_d + 1000;
        edge_at(f);
        wait_to(f + 30);
        check_strobe("after_period_99", f + 20, EXP_F);
        edge_at(f + 50);
        wait_to(f + 80);
        check_none("period_50_ignored");
        t_hh = f + 1000;
        edge_at(t_hh);
        wait_to(t_hh + 30);
        check_strobe("after_period_50", t_hh + 20, EXP_H);
    endtask

    // Reset 5 cycles into the division: no strobe, kmh cleared, two edges needed afterwards.
    task automatic test_reset_in_divide(input int t_hh, output int t_mm);
        int k;
        int l;
        k = t_hh + 1000;
        edge_at(k);
        wait_to(k + 8);
        reset = 1'b1;
        #1;
        checks++;
        if (kmh !== 7'd0) begin
            failures++;
            $display("FAIL reset_in_divide_kmh: got %0d required 0", kmh);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_to(k + 40);
        check_none("reset_in_divide_no_strobe");
        l = cyc + 10;
        edge_at(l);
        wait_to(l + 40);
        check_none("after_reset_first_edge");
        t_mm = l + 1000;
        edge_at(t_mm);
        wait_to(t_mm + 30);
        check_strobe("after_reset_second_edge", t_mm + 20, EXP_M);
    endtask

    // Counter reaches TIMEOUT 8192 cycles after the accept cycle (wheel rise + 3), strobe one cycle later.
    task automatic test_timeout(input int t_mm);
        int n;
        wait_to(t_mm + 8196 + 5);
        check_strobe("timeout_zero", t_mm + 8196, 0);
        checks++;
        if (kmh !== 7'd0) begin
            failures++;
            $display("FAIL timeout_kmh_hold: got %0d required 0", kmh);
        end
        n = cyc + 10;
        edge_at(n);
        wait_to(n + 40);
        check_none("after_timeout_single_edge");
    endtask

    initial begin
        int t_b;
        int t_d;
        test_reset();
        test_basic(t_b);
        test_speeds(t_b, t_d);
        test_short_edges(t_d, t_h);
        test_reset_in_divide(t_h, t_m);
        test_timeout(t_m);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
